uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//   Downstream consumer of the UART string receiver. Takes a received frame payload
//   (byte string + length + done pulse) and parses ASCII commands "K=<dec>[;K=<dec>...]".
//   Emits one register-write strobe per valid command. Feeds the control-register bank.
//   Scans one byte per clock.
// PARAMETERS
//   STR_BYTES  128  payload capacity in bytes (string bus width = STR_BYTES*8)
//   DATA_W     32   width of cmd_data (two's complement)
// PORTS
//   sys_clk     in   1            system clock; all logic on rising edge
//   sys_rst     in   1            synchronous, active-high reset
//   rx_string   in   STR_BYTES*8  payload; byte i = rx_string[8i+7:8i], byte 0 first
//   rx_length   in   8            payload length in bytes
//   rx_done     in   1            1-cycle pulse: rx_string/rx_length valid this cycle
//   cmd_vld     out  1            1-cycle strobe: cmd_addr/cmd_data valid
//   cmd_addr    out  5            key index, 'A'->0 .. 'Z'->25
//   cmd_data    out  DATA_W       parsed value
//   parse_err   out  1            1-cycle strobe: malformed or overflowing command
//   err_pos     out  8            byte index where the error was detected (valid with parse_err)
//   busy        out  1            high from the cycle after rx_done until done
//   done        out  1            1-cycle strobe: frame fully scanned
// BEHAVIOUR
// - Reset: all outputs 0; FSM returns to IDLE; buffers cleared. Reset mid-frame aborts
//   the frame with no strobes.
// - rx_done is sampled only in IDLE.
//   - In IDLE: latch string; len = min(rx_length, STR_BYTES); idx = 0.
//   - While busy: rx_done is ignored and the frame is dropped.
// - len == 0: IDLE -> DONE. done fires 2 cycles after rx_done; no cmd_vld.
// - FSM states: IDLE, KEY, EQ, SIGN, DIGIT, HEX (macro only), SKIP, DONE.
//   - One byte b = byte[idx] is consumed per cycle in KEY..SKIP; idx increments each cycle.
//   - Reaching idx == len is treated as the terminator ';' followed by end of frame.
// - KEY:   'A'..'Z' -> addr = b - "A", neg = 0, acc = 0, ndig = 0, -> EQ. Otherwise error.
// - EQ:    '=' -> SIGN. Otherwise error.
// - SIGN:  '-' -> neg = 1, -> DIGIT. '0'..'9' -> acc = d, ndig = 1, -> DIGIT. Otherwise error.
// - DIGIT: '0'..'9' -> acc = acc*10 + d, computed as (acc<<3)+(acc<<1)+d in a DATA_W+1-bit
//   accumulator; ndig++.
//   - acc > 2^(DATA_W-1)-1 (neg = 0) or acc > 2^(DATA_W-1) (neg = 1) -> error (overflow).
//   - ';' or end: if ndig == 0 -> error. Otherwise emit the command, then -> KEY, or -> DONE at end.
//   - Any other byte -> error.
// - Emit: next cycle cmd_vld = 1, cmd_addr = addr, cmd_data = neg ? -acc : acc.
//   - Parsing continues without stall, so back-to-back commands can give cmd_vld on
//     cycles k and k+4 ("A=1;B=2").
// - Error: next cycle parse_err = 1 and err_pos = idx of the offending byte.
//   - End-of-frame errors report err_pos = len.
//   - FSM -> SKIP, which discards bytes until ';' (-> KEY) or end (-> DONE).
//   - Only one parse_err per command.
// - DONE: done = 1 for one cycle, busy drops in the same cycle, -> IDLE.
//   - A new rx_done is accepted in the following cycle.
// - cmd_vld and parse_err never assert in the same cycle.
// - Empty segments (";;") are an error: a terminator in KEY is invalid.
// CONFIGURATION
//   UART_CMD_HEX_EN defined:
//   - In DIGIT with ndig == 1, acc == 0, neg == 0, b in {'x','X'} -> HEX.
//   - HEX accepts 0-9, a-f, A-F: acc = (acc<<4) | nibble.
//   - More than DATA_W/4 digits -> error. Zero digits before the terminator -> error.
//   - Value is loaded raw into cmd_data (no sign applied).
//   UART_CMD_HEX_EN undefined:
//   - No HEX state. 'x'/'X' in DIGIT is an error like any non-digit.
// TESTING
//   1. "A=123", len 5 -> one cmd_vld, addr 0, data 123; done; no parse_err.
//   2. "B=-45;Z=7", len 9 -> cmd_vld (1, -45 = 0xFFFFFFD3), then cmd_vld (25, 7) 4 cycles later;
//      one done.
//   3. Overflow:
//      - "C=2147483648" -> parse_err, err_pos 11, no cmd_vld.
//      - "C=-2147483648" -> cmd_vld, data 0x80000000.
//   4. "a=1;D=9", "E=", "F=1x" (macro off) -> errors at pos 0 / 2 / 3.
//      - "a=1;D=9" still yields cmd_vld (3, 9) after SKIP.
//      - len 0 -> done only.
//   5. Second rx_done while busy is ignored. Reset asserted mid-frame -> no strobes;
//      all outputs 0 next cycle.
//   6. UART_CMD_HEX_EN: "G=0x1F" -> data 31; "G=0x123456789" -> parse_err; "G=0x" -> parse_err.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Parses a received UART frame payload of the form "K=<dec>[;K=<dec>...]",
//   scanning one byte per clock. It emits one register-write strobe per valid
//   command and one error strobe per malformed or overflowing command.
//
//   Optional feature: define UART_CMD_HEX_EN to accept hex values "K=0x<hex>".
//   A hex value is loaded raw into cmd_data, with no sign applied.
//
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst    : synchronous active-high reset
//   rx_string  : payload, byte i = rx_string[8i+7:8i]
//   rx_length  : payload length in bytes (clamped to STR_BYTES)
//   rx_done    : 1-cycle frame-valid pulse (sampled only when idle)
//   cmd_vld    : 1-cycle strobe qualifying cmd_addr/cmd_data
//   cmd_addr   : key index, 'A'->0 .. 'Z'->25
//   cmd_data   : parsed two's-complement value
//   parse_err  : 1-cycle error strobe, err_pos = offending byte index
//   busy       : high while a frame is being scanned
//   done       : 1-cycle strobe, frame fully scanned
module uart_cmd_parser #(
  parameter int STR_BYTES = 128,
  parameter int DATA_W    = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [STR_BYTES*8-1:0] rx_string,
  input  logic [7:0]             rx_length,
  input  logic                   rx_done,
  output logic                   cmd_vld,
  output logic [4:0]             cmd_addr,
  output logic [DATA_W-1:0]      cmd_data,
  output logic                   parse_err,
  output logic [7:0]             err_pos,
  output logic                   busy,
  output logic                   done
);

`ifdef UART_CMD_HEX_EN
  typedef enum logic [2:0] {IDLE, KEY, EQ, SIGN, DIGIT, HEX, SKIP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, KEY, EQ, SIGN, DIGIT, SKIP, DONE} state_t;
`endif

  // Magnitude limits: the negative side may reach 2^(DATA_W-1).
  localparam logic [DATA_W+4:0] LIM_NEG = {5'b0, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W+4:0] LIM_POS = LIM_NEG - 1'b1;

  state_t                   state;
  logic [STR_BYTES*8-1:0]   str_q;   // shifted right one byte per scanned byte
  logic [7:0]               len_q;
  logic [7:0]               idx;
  logic [4:0]               addr_q;
  logic                     neg_q;
  logic [DATA_W:0]          acc_q;
  logic [7:0]               ndig_q;

  logic [7:0]               b;
  logic                     at_end, term, is_dig, is_uc;
  logic [3:0]               d;
  logic [DATA_W+4:0]        acc_x10;
  logic                     ovf;
  logic [DATA_W:0]          acc_neg;
  logic                     err_c, emit_c;
`ifdef UART_CMD_HEX_EN
  logic                     is_hex, hex_start;
  logic [3:0]               nib;
`endif

  assign b       = str_q[7:0];
  assign at_end  = (idx == len_q);
  // End of frame behaves like a ';' terminator.
  assign term    = at_end || (b == ";");
  assign is_dig  = (b >= "0") && (b <= "9");
  assign is_uc   = (b >= "A") && (b <= "Z");
  assign d       = b[3:0];
  // Product is computed with extra headroom so that it cannot wrap before
  // the overflow compare.
  assign acc_x10 = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                 + {{(DATA_W+1){1'b0}}, d};
  assign ovf     = acc_x10 > (neg_q ? LIM_NEG : LIM_POS);
  assign acc_neg = -acc_q;

`ifdef UART_CMD_HEX_EN
  assign is_hex    = is_dig || ((b >= "a") && (b <= "f")) || ((b >= "A") && (b <= "F"));
  // Letters a-f/A-F have low nibble 1..6.
  assign nib       = is_dig ? b[3:0] : b[3:0] + 4'd9;
  assign hex_start = (ndig_q == 8'd1) && (acc_q == '0) && !neg_q && ((b == "x") || (b == "X"));
`endif

  // Decode of the byte under the cursor: error or command completion.
  always_comb begin
    err_c  = 1'b0;
    emit_c = 1'b0;
    case (state)
      KEY:   err_c = at_end || !is_uc;
      EQ:    err_c = at_end || (b != "=");
      SIGN:  err_c = at_end || !((b == "-") || is_dig);
      DIGIT: begin
        if (term) begin
          err_c  = (ndig_q == 8'd0);
          emit_c = (ndig_q != 8'd0);
        end else if (is_dig) begin
          err_c = ovf;
`ifdef UART_CMD_HEX_EN
        end else if (hex_start) begin
          err_c = 1'b0;
`endif
        end else begin
          err_c = 1'b1;
        end
      end
`ifdef UART_CMD_HEX_EN
      HEX: begin
        if (term) begin
          err_c  = (ndig_q == 8'd0);
          emit_c = (ndig_q != 8'd0);
        end else if (is_hex) begin
          err_c = (ndig_q == 8'(DATA_W/4));
        end else begin
          err_c = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      str_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      addr_q    <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      ndig_q    <= '0;
      cmd_vld   <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      parse_err <= 1'b0;
      err_pos   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmd_vld   <= 1'b0;
      parse_err <= 1'b0;
      done      <= 1'b0;

      if (state != IDLE && state != DONE) begin
        idx   <= idx + 8'd1;
        str_q <= str_q >> 8;
      end

      if (err_c) begin
        parse_err <= 1'b1;
        err_pos   <= idx;
        // An error found on a ';' has already consumed the terminator,
        // so the next command starts right away.
        if (at_end)         state <= DONE;
        else if (b == ";")  state <= KEY;
        else                state <= SKIP;
      end else if (emit_c) begin
        cmd_vld  <= 1'b1;
        cmd_addr <= addr_q;
        cmd_data <= neg_q ? acc_neg[DATA_W-1:0] : acc_q[DATA_W-1:0];
        state    <= at_end ? DONE : KEY;
      end else begin
        case (state)
          IDLE: if (rx_done) begin
            str_q <= rx_string;
            len_q <= (int'(rx_length) > STR_BYTES) ? 8'(STR_BYTES) : rx_length;
            idx   <= '0;
            busy  <= 1'b1;
            state <= (rx_length == 8'd0) ? DONE : KEY;
          end
          KEY: begin
            addr_q <= 5'(b - 8'd65);
            neg_q  <= 1'b0;
            acc_q  <= '0;
            ndig_q <= '0;
            state  <= EQ;
          end
          EQ:   state <= SIGN;
          SIGN: begin
            if (b == "-") begin
              neg_q <= 1'b1;
            end else begin
              acc_q  <= {{(DATA_W-3){1'b0}}, d};
              ndig_q <= 8'd1;
            end
            state <= DIGIT;
          end
          DIGIT: begin
`ifdef UART_CMD_HEX_EN
            if (hex_start) begin
              ndig_q <= '0;
              state  <= HEX;
            end else begin
              acc_q  <= acc_x10[DATA_W:0];
              ndig_q <= ndig_q + 8'd1;
            end
`else
            acc_q  <= acc_x10[DATA_W:0];
            ndig_q <= ndig_q + 8'd1;
`endif
          end
`ifdef UART_CMD_HEX_EN
          HEX: begin
            acc_q  <= {acc_q[DATA_W-4:0], nib};
            ndig_q <= ndig_q + 8'd1;
          end
`endif
          SKIP: begin
            if (at_end)        state <= DONE;
            else if (b == ";") state <= KEY;
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
  localparam int SB = 128;
  localparam int DW = 32;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [SB*8-1:0] rx_string = '0;
  logic [7:0]      rx_length = '0;
  logic            rx_done = 1'b0;
  logic            cmd_vld, parse_err, busy, done;
  logic [4:0]      cmd_addr;
  logic [DW-1:0]   cmd_data;
  logic [7:0]      err_pos;

  uart_cmd_parser #(.STR_BYTES(SB), .DATA_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_string(rx_string),
    .rx_length(rx_length), .rx_done(rx_done), .cmd_vld(cmd_vld),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .parse_err(parse_err),
    .err_pos(err_pos), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event recorder
  int            cv_addr[$];
  logic [DW-1:0] cv_data[$];
  int            cv_cyc[$];
  int            pe_pos[$];
  int            dn_cyc[$];
  int            both_cnt = 0;
  int            t_send = 0;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (cmd_vld)   begin cv_addr.push_back(int'(cmd_addr)); cv_data.push_back(cmd_data); cv_cyc.push_back(cyc); end
      if (parse_err) pe_pos.push_back(int'(err_pos));
      if (done)      dn_cyc.push_back(cyc);
      if (cmd_vld && parse_err) both_cnt <= both_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cv_addr.delete(); cv_data.delete(); cv_cyc.delete();
    pe_pos.delete(); dn_cyc.delete();
  endtask

  task automatic send(input string s, input int len);
    logic [SB*8-1:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
    @(negedge sys_clk);
    rx_string = v;
    rx_length = len[7:0];
    rx_done   = 1'b1;
    t_send    = cyc;
    @(negedge sys_clk);
    rx_done   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dn_cyc.size() == 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(n < 400), 64'd1);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
    chk("rst_parse_err", 64'(parse_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cmd_data", 64'(cmd_data), 64'd0);

    // single decimal command
    clr(); send("A=123", 5);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");
    chk("t1_ncmd", 64'(cv_addr.size()), 64'd1);
    if (cv_addr.size() == 1) begin
      chk("t1_addr", 64'(cv_addr[0]), 64'd0);
      chk("t1_data", 64'(cv_data[0]), 64'd123);
    end
    chk("t1_nerr", 64'(pe_pos.size()), 64'd0);
    chk("t1_ndone", 64'(dn_cyc.size()), 64'd1);

    // negative + second command four cycles later
    clr(); send("B=-45;Z=7", 9); wait_done("t2");
    chk("t2_ncmd", 64'(cv_addr.size()), 64'd2);
    if (cv_addr.size() == 2) begin
      chk("t2_addr0", 64'(cv_addr[0]), 64'd1);
      chk("t2_data0", 64'(cv_data[0]), 64'hFFFF_FFD3);
      chk("t2_addr1", 64'(cv_addr[1]), 64'd25);
      chk("t2_data1", 64'(cv_data[1]), 64'd7);
      chk("t2_gap", 64'(cv_cyc[1] - cv_cyc[0]), 64'd4);
    end
    chk("t2_ndone", 64'(dn_cyc.size()), 64'd1);

    // positive overflow
    clr(); send("C=2147483648", 12); wait_done("t3a");
    chk("t3a_nerr", 64'(pe_pos.size()), 64'd1);
    if (pe_pos.size() == 1) chk("t3a_pos", 64'(pe_pos[0]), 64'd11);
    chk("t3a_ncmd", 64'(cv_addr.size()), 64'd0);

    // most negative value fits
    clr(); send("C=-2147483648", 13); wait_done("t3b");
    chk("t3b_ncmd", 64'(cv_addr.size()), 64'd1);
    if (cv_addr.size() == 1) chk("t3b_data", 64'(cv_data[0]), 64'h8000_0000);
    chk("t3b_nerr", 64'(pe_pos.size()), 64'd0);

    // bad key, then recovery after SKIP
    clr(); send("a=1;D=9", 7); wait_done("t4a");
    chk("t4a_nerr", 64'(pe_pos.size()), 64'd1);
    if (pe_pos.size() == 1) chk("t4a_pos", 64'(pe_pos[0]), 64'd0);
    chk("t4a_ncmd", 64'(cv_addr.size()), 64'd1);
    if (cv_addr.size() == 1) begin
      chk("t4a_addr", 64'(cv_addr[0]), 64'd3);
      chk("t4a_data", 64'(cv_data[0]), 64'd9);
    end

    // missing value at end of frame
    clr(); send("E=", 2); wait_done("t4b");
    chk("t4b_nerr", 64'(pe_pos.size()), 64'd1);
    if (pe_pos.size() == 1) chk("t4b_pos", 64'(pe_pos[0]), 64'd2);
    chk("t4b_ncmd", 64'(cv_addr.size()), 64'd0);

    // empty frame
    clr(); send("", 0); wait_done("t4c");
    chk("t4c_ndone", 64'(dn_cyc.size()), 64'd1);
    if (dn_cyc.size() == 1) chk("t4c_lat", 64'(dn_cyc[0] - t_send), 64'd2);
    chk("t4c_ncmd", 64'(cv_addr.size()), 64'd0);
    chk("t4c_nerr", 64'(pe_pos.size()), 64'd0);

`ifdef UART_CMD_HEX_EN
    clr(); send("G=0x1F", 6); wait_done("t6a");
    chk("t6a_ncmd", 64'(cv_addr.size()), 64'd1);
    if (cv_addr.size() == 1) begin
      chk("t6a_addr", 64'(cv_addr[0]), 64'd6);
      chk("t6a_data", 64'(cv_data[0]), 64'd31);
    end
    clr(); send("G=0x123456789", 13); wait_done("t6b");
    chk("t6b_nerr", 64'(pe_pos.size()), 64'd1);
    if (pe_pos.size() == 1) chk("t6b_pos", 64'(pe_pos[0]), 64'd12);
    chk("t6b_ncmd", 64'(cv_addr.size()), 64'd0);
    clr(); send("G=0x", 4); wait_done("t6c");
    chk("t6c_nerr", 64'(pe_pos.size()), 64'd1);
    if (pe_pos.size() == 1) chk("t6c_pos", 64'(pe_pos[0]), 64'd4);
`else
    clr(); send("F=1x", 4); wait_done("t4d");
    chk("t4d_nerr", 64'(pe_pos.size()), 64'd1);
    if (pe_pos.size() == 1) chk("t4d_pos", 64'(pe_pos[0]), 64'd3);
    chk("t4d_ncmd", 64'(cv_addr.size()), 64'd0);
`endif

    // second rx_done while busy is dropped
    clr(); send("A=1", 3); send("B=2", 3); wait_done("t5a");
    repeat (20) @(negedge sys_clk);
    chk("t5a_ncmd", 64'(cv_addr.size()), 64'd1);
    if (cv_addr.size() == 1) chk("t5a_addr", 64'(cv_addr[0]), 64'd0);
    chk("t5a_ndone", 64'(dn_cyc.size()), 64'd1);

    // reset mid-frame
    clr(); send("A=12345678", 10);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t5b_busy", 64'(busy), 64'd0);
    chk("t5b_cmd_data", 64'(cmd_data), 64'd0);
    chk("t5b_flags", 64'({cmd_vld, parse_err, done}), 64'd0);
    chk("t5b_err_pos", 64'(err_pos), 64'd0);
    sys_rst = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("t5b_nstrobes", 64'(cv_addr.size() + pe_pos.size() + dn_cyc.size()), 64'd0);

    chk("excl_vld_err", 64'(both_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
